// File: rtl/lsu_mem_stage.sv
// Memory-stage load/store unit: turns byte/half/word RISC-V ops into word-wide
// cache transactions, with load extension and read-modify-write for sub-word stores.
module lsu_mem_stage #(
  parameter int ADDR_SIZE = 32,
  parameter int DATA_SIZE = 32
) (
  input  logic                 i_aclk,
  input  logic                 i_reset,
  input  logic                 i_valid,
  input  logic                 i_is_store,
  input  logic [2:0]           i_funct3,
  input  logic [ADDR_SIZE-1:0] i_addr,
  input  logic [DATA_SIZE-1:0] i_wdata,
  output logic                 o_ready,
  output logic                 o_done,
  output logic                 o_exc,
  output logic [DATA_SIZE-1:0] o_rdata,
  output logic                 o_req,
  output logic                 o_req_write,
  output logic [ADDR_SIZE-1:0] o_addr,
  output logic [DATA_SIZE-1:0] o_store_data,
  input  logic                 i_req_ready,
  input  logic                 i_data_valid,
  input  logic [DATA_SIZE-1:0] i_data
);

  typedef enum logic [2:0] {
    S_IDLE, S_RD_REQ, S_RD_WAIT, S_WR_REQ, S_WR_WAIT, S_DONE, S_EXC
  } state_e;

  state_e               state_q, state_d;
  logic [ADDR_SIZE-1:0] addr_q, addr_d;
  logic [2:0]           f3_q, f3_d;
  logic                 store_q, store_d;
  logic [DATA_SIZE-1:0] wdata_q, wdata_d;
  logic [DATA_SIZE-1:0] word_q, word_d;
  logic [DATA_SIZE-1:0] rdata_q, rdata_d;
  logic [1:0]           off;

  assign off = addr_q[1:0];

  function automatic logic legal_op(input logic st, input logic [2:0] f3,
                                    input logic [1:0] o);
    logic ok_f3, ok_al;
    if (st) ok_f3 = (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b010);
    else    ok_f3 = (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b010) ||
                    (f3 == 3'b100) || (f3 == 3'b101);
    case (f3[1:0])
      2'b01:   ok_al = ~o[0];
      2'b10:   ok_al = (o == 2'b00);
      default: ok_al = 1'b1;
    endcase
    return ok_f3 && ok_al;
  endfunction

  function automatic logic [DATA_SIZE-1:0] load_ext(input logic [DATA_SIZE-1:0] w,
                                                    input logic [2:0] f3,
                                                    input logic [1:0] o);
    logic [4:0]           bsh, hsh;
    logic [7:0]           b;
    logic [15:0]          h;
    logic [DATA_SIZE-1:0] r;
    bsh = {o, 3'b000};
    hsh = {o[1], 4'b0000};
    b   = w[bsh +: 8];
    h   = w[hsh +: 16];
    case (f3)
      3'b000:  r = {{(DATA_SIZE-8){b[7]}}, b};
      3'b001:  r = {{(DATA_SIZE-16){h[15]}}, h};
      3'b100:  r = {{(DATA_SIZE-8){1'b0}}, b};
      3'b101:  r = {{(DATA_SIZE-16){1'b0}}, h};
      default: r = w;
    endcase
    return r;
  endfunction

  function automatic logic [DATA_SIZE-1:0] store_merge(input logic [DATA_SIZE-1:0] w,
                                                       input logic [DATA_SIZE-1:0] wd,
                                                       input logic [2:0] f3,
                                                       input logic [1:0] o);
    logic [4:0]           bsh, hsh;
    logic [DATA_SIZE-1:0] r;
    bsh = {o, 3'b000};
    hsh = {o[1], 4'b0000};
    r   = w;
    case (f3[1:0])
      2'b00:   r[bsh +: 8]  = wd[7:0];
      2'b01:   r[hsh +: 16] = wd[15:0];
      default: r = wd;
    endcase
    return r;
  endfunction

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    f3_d    = f3_q;
    store_d = store_q;
    wdata_d = wdata_q;
    word_d  = word_q;
    rdata_d = rdata_q;
    case (state_q)
      S_IDLE: begin
        if (i_valid) begin
          addr_d  = i_addr;
          f3_d    = i_funct3;
          store_d = i_is_store;
          wdata_d = i_wdata;
          if (!legal_op(i_is_store, i_funct3, i_addr[1:0])) begin
            state_d = S_EXC;
          end else if (i_is_store && i_funct3 == 3'b010) begin
            word_d  = i_wdata;
            state_d = S_WR_REQ;
          end else begin
            state_d = S_RD_REQ;
          end
        end
      end
      S_RD_REQ:  if (i_req_ready) state_d = S_RD_WAIT;
      S_RD_WAIT: begin
        if (i_data_valid) begin
          // Sub-word stores reuse the read word as the base of the write.
          if (store_q) begin
            word_d  = store_merge(i_data, wdata_q, f3_q, off);
            state_d = S_WR_REQ;
          end else begin
            rdata_d = load_ext(i_data, f3_q, off);
            state_d = S_DONE;
          end
        end
      end
      S_WR_REQ:  if (i_req_ready) state_d = S_WR_WAIT;
      S_WR_WAIT: if (i_data_valid) state_d = S_DONE;
      S_DONE:    state_d = S_IDLE;
      S_EXC:     state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_aclk) begin
    if (i_reset) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      f3_q    <= '0;
      store_q <= 1'b0;
      wdata_q <= '0;
      word_q  <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      f3_q    <= f3_d;
      store_q <= store_d;
      wdata_q <= wdata_d;
      word_q  <= word_d;
      rdata_q <= rdata_d;
    end
  end

  assign o_ready      = (state_q == S_IDLE);
  assign o_done       = (state_q == S_DONE) || (state_q == S_EXC);
  assign o_exc        = (state_q == S_EXC);
  assign o_rdata      = rdata_q;
  assign o_req        = (state_q == S_RD_REQ) || (state_q == S_WR_REQ);
  assign o_req_write  = (state_q == S_WR_REQ);
  assign o_addr       = {addr_q[ADDR_SIZE-1:2], 2'b00};
  assign o_store_data = word_q;

endmodule

// File: tb/tb_lsu_mem_stage.sv
// Directed bench for lsu_mem_stage with a small zero-wait cache responder.
module tb_lsu_mem_stage;
  logic        clk = 1'b0;
  logic        rst;
  logic        valid, is_store;
  logic [2:0]  funct3;
  logic [31:0] addr, wdata;
  logic        ready, done, exc, req, req_write;
  logic [31:0] rdata, req_addr, store_data;
  logic        req_ready, dv_m, dv_inj;
  logic        data_valid;
  logic [31:0] rd_word, inj_data, cache_data;

  int          n_chk = 0, n_err = 0;
  int          rd_cnt, wr_cnt, req_seen, stall_left;
  logic        hold_resp, pend;
  logic [31:0] last_rd_addr, last_wr_addr, last_wr_data;

  assign data_valid = dv_m | dv_inj;
  assign cache_data = dv_inj ? inj_data : rd_word;

  always #5 clk = ~clk;

  lsu_mem_stage #(.ADDR_SIZE(32), .DATA_SIZE(32)) dut (
    .i_aclk(clk), .i_reset(rst), .i_valid(valid), .i_is_store(is_store),
    .i_funct3(funct3), .i_addr(addr), .i_wdata(wdata),
    .o_ready(ready), .o_done(done), .o_exc(exc), .o_rdata(rdata),
    .o_req(req), .o_req_write(req_write), .o_addr(req_addr),
    .o_store_data(store_data), .i_req_ready(req_ready),
    .i_data_valid(data_valid), .i_data(cache_data)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h want 0x%08h", tag, obs, exp);
    end
  endtask

  // Cache responder: answers one cycle after an accepted request.
  initial begin
    req_ready = 1'b0; dv_m = 1'b0; pend = 1'b0;
    forever begin
      @(negedge clk);
      dv_m = pend && !hold_resp;
      pend = 1'b0;
      if (req && !rst) begin
        req_seen++;
        if (stall_left > 0) begin
          req_ready = 1'b0;
          stall_left--;
        end else begin
          req_ready = 1'b1;
          pend      = 1'b1;
          if (req_write) begin
            wr_cnt++; last_wr_addr = req_addr; last_wr_data = store_data;
          end else begin
            rd_cnt++; last_rd_addr = req_addr;
          end
        end
      end else begin
        req_ready = 1'b0;
      end
    end
  end

  task automatic clr_log();
    rd_cnt = 0; wr_cnt = 0; req_seen = 0; stall_left = 0;
    last_rd_addr = '0; last_wr_addr = '0; last_wr_data = '0;
  endtask

  task automatic start_op(input logic st, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] wd);
    @(negedge clk);
    valid = 1'b1; is_store = st; funct3 = f3; addr = a; wdata = wd;
    @(posedge clk);
    #1 valid = 1'b0;
  endtask

  task automatic wait_done(output int lat, output logic e);
    lat = -1; e = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (done) begin lat = c; e = exc; break; end
    end
  endtask

  task automatic do_op(input logic st, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd, output int lat, output logic e);
    start_op(st, f3, a, wd);
    wait_done(lat, e);
  endtask

  int   lat, lat2;
  logic e;

  initial begin
    rst = 1'b1; valid = 1'b0; is_store = 1'b0; funct3 = '0; addr = '0; wdata = '0;
    dv_inj = 1'b0; inj_data = '0; rd_word = '0; hold_resp = 1'b0;
    clr_log();
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    @(negedge clk);
    chk("rst_ready", {31'b0, ready}, 32'd1);
    chk("rst_done",  {31'b0, done},  32'd0);
    chk("rst_exc",   {31'b0, exc},   32'd0);
    chk("rst_req",   {30'b0, req, req_write}, 32'd0);
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_addr",  req_addr, 32'h0);
    chk("rst_sdata", store_data, 32'h0);

    // LW
    clr_log(); rd_word = 32'hDEAD_BEEF;
    do_op(1'b0, 3'b010, 32'h100, 32'h0, lat, e);
    chk("lw_lat",   lat, 32'd3);
    chk("lw_exc",   {31'b0, e}, 32'd0);
    chk("lw_rdata", rdata, 32'hDEAD_BEEF);
    chk("lw_raddr", last_rd_addr, 32'h100);
    chk("lw_cnt",   {rd_cnt[15:0], wr_cnt[15:0]}, {16'd1, 16'd0});
    @(negedge clk);
    chk("lw_pulse", {30'b0, done, ready}, 32'd1);

    // Sub-word loads
    rd_word = 32'h80FF_1234;
    do_op(1'b0, 3'b000, 32'h103, 32'h0, lat, e);
    chk("lb_rdata", rdata, 32'hFFFF_FF80);
    do_op(1'b0, 3'b100, 32'h103, 32'h0, lat, e);
    chk("lbu_rdata", rdata, 32'h0000_0080);
    do_op(1'b0, 3'b001, 32'h102, 32'h0, lat, e);
    chk("lh_rdata", rdata, 32'hFFFF_80FF);
    do_op(1'b0, 3'b101, 32'h100, 32'h0, lat, e);
    chk("lhu_rdata", rdata, 32'h0000_1234);
    chk("lhu_lat", lat, 32'd3);

    // SB / SH read-modify-write
    clr_log(); rd_word = 32'h1122_3344;
    do_op(1'b1, 3'b000, 32'h102, 32'h0000_00AB, lat, e);
    chk("sb_lat",   lat, 32'd5);
    chk("sb_cnt",   {rd_cnt[15:0], wr_cnt[15:0]}, {16'd1, 16'd1});
    chk("sb_waddr", last_wr_addr, 32'h100);
    chk("sb_wdata", last_wr_data, 32'h11AB_3344);
    chk("sb_rdata_keep", rdata, 32'h0000_1234);
    do_op(1'b1, 3'b001, 32'h102, 32'hFFFF_BEEF, lat, e);
    chk("sh_wdata", last_wr_data, 32'hBEEF_3344);

    // Exceptions: no cache traffic, rdata untouched
    clr_log();
    do_op(1'b0, 3'b001, 32'h101, 32'h0, lat, e);
    chk("lh_mis_lat", lat, 32'd1);
    chk("lh_mis_exc", {31'b0, e}, 32'd1);
    do_op(1'b1, 3'b010, 32'h106, 32'h1234_5678, lat, e);
    chk("sw_mis_lat", lat, 32'd1);
    chk("sw_mis_exc", {31'b0, e}, 32'd1);
    do_op(1'b0, 3'b011, 32'h100, 32'h0, lat, e);
    chk("ld_f3_exc", {31'b0, e}, 32'd1);
    do_op(1'b1, 3'b100, 32'h100, 32'h0, lat, e);
    chk("st_f3_exc", {31'b0, e}, 32'd1);
    chk("exc_noreq", req_seen, 32'd0);
    chk("exc_rdata", rdata, 32'h0000_1234);

    // SW with 4-cycle request stall
    clr_log(); stall_left = 4;
    start_op(1'b1, 3'b010, 32'h200, 32'hCAFE_F00D);
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      chk("stall_req", {30'b0, req, req_write}, 32'd3);
      chk("stall_addr", req_addr, 32'h200);
      chk("stall_sdata", store_data, 32'hCAFE_F00D);
    end
    wait_done(lat2, e);
    chk("stall_lat", lat2 + 4, 32'd7);
    chk("stall_cnt", {rd_cnt[15:0], wr_cnt[15:0]}, {16'd0, 16'd1});
    chk("stall_wdata", last_wr_data, 32'hCAFE_F00D);
    do_op(1'b1, 3'b010, 32'h204, 32'h0BAD_0001, lat, e);
    chk("sw_lat", lat, 32'd3);

    // Reset in RD_WAIT, then a stale response
    clr_log(); hold_resp = 1'b1; rd_word = 32'h7777_7777;
    start_op(1'b0, 3'b010, 32'h300, 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_rst_ready", {31'b0, ready}, 32'd1);
    chk("mid_rst_req",   {31'b0, req},   32'd0);
    hold_resp = 1'b0;
    @(negedge clk);
    @(negedge clk);
    dv_inj = 1'b1; inj_data = 32'h5555_5555;
    @(negedge clk);
    dv_inj = 1'b0;
    chk("stale_done",  {31'b0, done}, 32'd0);
    chk("stale_ready", {31'b0, ready}, 32'd1);
    @(negedge clk);
    chk("stale_rdata", rdata, 32'h0);
    rd_word = 32'h0BAD_F00D;
    do_op(1'b0, 3'b010, 32'h300, 32'h0, lat, e);
    chk("post_lat",   lat, 32'd3);
    chk("post_rdata", rdata, 32'h0BAD_F00D);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
